// File: rtl/bnn_weight_streamer_if.sv
// Host-side and core-side signal bundle of the BNN nibble weight streamer.
// The slave modport is the streamer itself; the master modport is the host/core side.
interface bnn_weight_streamer_if #(
   parameter int unsigned ADDR_W = 4
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              wr_err;
   logic              start;
   logic              hold;
   logic              abort;
   logic              load_en;
   logic [3:0]        weight_nib;
   logic              busy;
   logic              done;
   logic              aborted;
   logic [ADDR_W-1:0] word_idx;

   modport master (
      output wr_en, wr_addr, wr_data, start, hold, abort,
      input  wr_err, load_en, weight_nib, busy, done, aborted, word_idx
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, hold, abort,
      output wr_err, load_en, weight_nib, busy, done, aborted, word_idx
   );
endinterface

// File: rtl/bnn_weight_streamer.sv
// Transmit side of the BNN nibble weight-load interface: a small weight register file
// streamed to the core as {low nibble, high nibble} pairs on load_en / weight_nib.
module bnn_weight_streamer #(
   parameter int unsigned NUM_NEURONS = 12,
   parameter int unsigned ADDR_W      = 4
) (
   input  logic                clk,
   input  logic                reset,
   bnn_weight_streamer_if.slave bus
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSendLo = 2'd1;
   localparam logic [1:0] StSendHi = 2'd2;
   localparam logic [1:0] StDone   = 2'd3;

   localparam logic [ADDR_W:0]   NumWords = (ADDR_W + 1)'(NUM_NEURONS);
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_NEURONS - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              abort_q, abort_d;
   logic              early_q, early_d;
   logic              wr_err_q;
   logic [7:0]        mem_q [NUM_NEURONS];

   logic in_send;
   logic busy;
   logic addr_ok;
   logic wr_ok;

   assign in_send = (state_q == StSendLo) || (state_q == StSendHi);
   assign busy    = (state_q != StIdle);
   assign addr_ok = ({1'b0, bus.wr_addr} < NumWords);
   assign wr_ok   = bus.wr_en && !busy && addr_ok;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      abort_d = abort_q;
      early_d = early_q;
      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            early_d = 1'b0;
            if (bus.start) begin
               state_d = StSendLo;
               idx_d   = '0;
            end
         end
         StSendLo: begin
            abort_d = abort_q | bus.abort;
            if (!bus.hold) state_d = StSendHi;
         end
         StSendHi: begin
            abort_d = abort_q | bus.abort;
            // Abort only takes effect here, so the core never sees half a nibble pair.
            if (!bus.hold) begin
               if (idx_q == LastIdx || abort_q || bus.abort) begin
                  state_d = StDone;
                  idx_d   = '0;
                  early_d = (idx_q != LastIdx);
               end else begin
                  state_d = StSendLo;
                  idx_d   = idx_q + ADDR_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         abort_q  <= 1'b0;
         early_q  <= 1'b0;
         wr_err_q <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         abort_q  <= abort_d;
         early_q  <= early_d;
         wr_err_q <= bus.wr_en && (busy || !addr_ok);
         if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_comb begin
      bus.weight_nib = 4'h0;
      if (state_q == StSendLo)      bus.weight_nib = mem_q[idx_q][3:0];
      else if (state_q == StSendHi) bus.weight_nib = mem_q[idx_q][7:4];
   end

   // load_en is deliberately combinational from hold so a stall drops it the same cycle.
   assign bus.load_en  = in_send && !bus.hold;
   assign bus.busy     = busy;
   assign bus.done     = (state_q == StDone);
   assign bus.aborted  = (state_q == StDone) && early_q;
   assign bus.wr_err   = wr_err_q;
   assign bus.word_idx = idx_q;

endmodule
